// File: rtl/turbo_out_packer_if.sv
// Pair-in / byte-out stream bundle for the turbo encoder output packer.
// The slave side is the packer; the master side drives pairs and consumes bytes.
interface turbo_out_packer_if;
  logic       in_valid;
  logic       in_bit0;
  logic       in_bit1;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  modport master (
    output in_valid, in_bit0, in_bit1, out_ready,
    input  out_data, out_valid, out_last
  );

  modport slave (
    input  in_valid, in_bit0, in_bit1, out_ready,
    output out_data, out_valid, out_last
  );
endinterface

// File: rtl/turbo_out_packer.sv
// Packs turbo encoder output pairs four-to-a-byte, zero-pads the frame-final
// byte, and queues {last, data} words in a first-word-fall-through FIFO.
module turbo_out_packer #(
  parameter int FRAME_PAIRS = 4096,
  parameter int DEPTH       = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  turbo_out_packer_if.slave          s,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level,
  output logic                       overflow,
  output logic                       frame_done
);

  localparam int CW = (FRAME_PAIRS > 1) ? $clog2(FRAME_PAIRS) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] LAST_PAIR = CW'(FRAME_PAIRS - 1);
  localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
  localparam logic [LW-1:0] ONE_LVL   = LW'(1);

  logic [CW-1:0] pair_cnt_reg;
  logic [1:0]    slot_reg;
  logic [7:0]    pack_reg;
  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [LW-1:0] level_reg;
  logic [8:0]    head_reg;
  logic          overflow_reg;
  logic          frame_done_reg;

  logic          frame_end;
  logic          byte_done;
  logic          fifo_full;
  logic          pop;
  logic          push;
  logic          drop;
  logic [7:0]    byte_next;
  logic [8:0]    wr_word;
  logic [8:0]    head_next;
  logic [AW-1:0] rd_ptr_inc;

  // The incoming pair overwrites its slot; other slots come from the pack register.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_slot
      assign byte_next[7-2*gi] = (slot_reg == 2'(gi)) ? s.in_bit0 : pack_reg[7-2*gi];
      assign byte_next[6-2*gi] = (slot_reg == 2'(gi)) ? s.in_bit1 : pack_reg[6-2*gi];
    end
  endgenerate

  assign frame_end  = (pair_cnt_reg == LAST_PAIR);
  assign byte_done  = s.in_valid && ((slot_reg == 2'd3) || frame_end);
  assign fifo_full  = (level_reg == FULL_LVL);
  assign pop        = (level_reg != '0) && s.out_ready;
  assign push       = byte_done && (!fifo_full || pop);
  assign drop       = byte_done && fifo_full && !pop;
  assign wr_word    = {frame_end, byte_next};
  assign rd_ptr_inc = rd_ptr_reg + 1'b1;

  // Head register is what the next cycle will present; when the FIFO drains
  // it simply keeps the last popped word.
  always_comb begin
    head_next = head_reg;
    if (pop) begin
      if (level_reg == ONE_LVL) begin
        if (push) head_next = wr_word;
      end else begin
        head_next = mem[rd_ptr_inc];
      end
    end else if (push && (level_reg == '0)) begin
      head_next = wr_word;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= wr_word;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pair_cnt_reg   <= '0;
      slot_reg       <= 2'd0;
      pack_reg       <= 8'd0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      level_reg      <= '0;
      head_reg       <= 9'd0;
      overflow_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      if (s.in_valid) begin
        pair_cnt_reg <= frame_end ? '0 : pair_cnt_reg + 1'b1;
        slot_reg     <= byte_done ? 2'd0 : slot_reg + 2'd1;
        pack_reg     <= byte_done ? 8'd0 : byte_next;
      end
      frame_done_reg <= s.in_valid && frame_end;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_inc;
      if (push && !pop)      level_reg <= level_reg + 1'b1;
      else if (pop && !push) level_reg <= level_reg - 1'b1;
      if (drop) overflow_reg <= 1'b1;
      head_reg <= head_next;
    end
  end

  assign s.out_data  = head_reg[7:0];
  assign s.out_last  = head_reg[8];
  assign s.out_valid = (level_reg != '0);
  assign fifo_level  = level_reg;
  assign overflow    = overflow_reg;
  assign frame_done  = frame_done_reg;

endmodule

// File: tb/tb_turbo_out_packer.sv
// Directed bench: dut_a uses 4096-pair frames, dut_b uses 6-pair frames.
module tb_turbo_out_packer;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] lvl_a, lvl_b;
  logic       ov_a, ov_b, fd_a, fd_b;
  int         tests = 0;
  int         fails = 0;
  int         popped;
  logic [7:0] exp_b [9];

  turbo_out_packer_if ia ();
  turbo_out_packer_if ib ();

  turbo_out_packer #(.FRAME_PAIRS(4096), .DEPTH(8)) dut_a (
    .clk(clk), .reset(reset), .s(ia),
    .fifo_level(lvl_a), .overflow(ov_a), .frame_done(fd_a)
  );

  turbo_out_packer #(.FRAME_PAIRS(6), .DEPTH(8)) dut_b (
    .clk(clk), .reset(reset), .s(ib),
    .fifo_level(lvl_b), .overflow(ov_b), .frame_done(fd_b)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pair_a(input logic b0, input logic b1);
    ia.in_valid = 1'b1; ia.in_bit0 = b0; ia.in_bit1 = b1;
    tick();
    ia.in_valid = 1'b0;
  endtask

  task automatic pair_b(input logic b0, input logic b1);
    ib.in_valid = 1'b1; ib.in_bit0 = b0; ib.in_bit1 = b1;
    tick();
    ib.in_valid = 1'b0;
  endtask

  task automatic byte_a(input logic [7:0] v);
    for (int k = 0; k < 4; k++) pair_a(v[7-2*k], v[6-2*k]);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    ia.in_valid = 1'b0; ia.in_bit0 = 1'b0; ia.in_bit1 = 1'b0; ia.out_ready = 1'b0;
    ib.in_valid = 1'b0; ib.in_bit0 = 1'b0; ib.in_bit1 = 1'b0; ib.out_ready = 1'b0;
    tick();
    do_reset();

    check("rst_valid", ia.out_valid, 0);
    check("rst_data", ia.out_data, 0);
    check("rst_last", ia.out_last, 0);
    check("rst_level", lvl_a, 0);
    check("rst_ovf", ov_a, 0);
    check("rst_fdone", fd_a, 0);

    // Basic pack: 10 11 00 01 -> B1
    ia.out_ready = 1'b1;
    pair_a(1, 0); pair_a(1, 1); pair_a(0, 0);
    check("basic_early", ia.out_valid, 0);
    pair_a(0, 1);
    check("basic_valid", ia.out_valid, 1);
    check("basic_data", ia.out_data, 8'hB1);
    check("basic_last", ia.out_last, 0);
    tick();
    check("basic_drained", lvl_a, 0);
    ia.out_ready = 1'b0;

    // Frame padding on the 6-pair instance
    for (int k = 0; k < 4; k++) pair_b(1, 1);
    check("pad_b0_lvl", lvl_b, 1);
    check("pad_b0_data", ib.out_data, 8'hFF);
    check("pad_b0_last", ib.out_last, 0);
    pair_b(1, 1);
    check("pad_fd_early", fd_b, 0);
    pair_b(1, 1);
    check("pad_fd", fd_b, 1);
    check("pad_lvl2", lvl_b, 2);
    pair_b(1, 0);
    check("pad_fd_once", fd_b, 0);
    ib.out_ready = 1'b1;
    tick();
    check("pad_b1_data", ib.out_data, 8'hF0);
    check("pad_b1_last", ib.out_last, 1);
    tick();
    check("pad_empty", lvl_b, 0);
    pair_b(0, 0); pair_b(0, 0); pair_b(0, 1);
    check("newframe_valid", ib.out_valid, 1);
    check("newframe_data", ib.out_data, 8'h81);
    check("newframe_last", ib.out_last, 0);
    pair_b(1, 1); pair_b(0, 0);
    check("newframe_end_data", ib.out_data, 8'hC0);
    check("newframe_end_last", ib.out_last, 1);
    check("newframe_fd", fd_b, 1);
    tick();
    check("newframe_drained", lvl_b, 0);
    ib.out_ready = 1'b0;

    // Overflow: 9 bytes into an 8-deep FIFO with no consumer
    for (int i = 0; i < 9; i++) begin
      exp_b[i] = 8'(8'h11 * i + 8'h05);
      byte_a(exp_b[i]);
      check($sformatf("ovf_lvl%0d", i), lvl_a, (i < 8) ? i + 1 : 8);
      check($sformatf("ovf_flag%0d", i), ov_a, (i < 8) ? 0 : 1);
    end
    ia.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain_valid%0d", i), ia.out_valid, 1);
      check($sformatf("drain_data%0d", i), ia.out_data, exp_b[i]);
      tick();
    end
    check("drain_empty", ia.out_valid, 0);
    check("drain_ovf_sticky", ov_a, 1);
    ia.out_ready = 1'b0;

    // Reset mid-byte with bytes queued on the 6-pair instance
    for (int k = 0; k < 6; k++) pair_b(1, 1);
    for (int k = 0; k < 3; k++) pair_b(1, 0);
    check("mid_lvl_pre", lvl_b, 2);
    do_reset();
    check("mid_valid", ib.out_valid, 0);
    check("mid_data", ib.out_data, 0);
    check("mid_last", ib.out_last, 0);
    check("mid_lvl", lvl_b, 0);
    check("mid_ovf", ov_b, 0);
    check("mid_fd", fd_b, 0);
    check("mid_ovf_a", ov_a, 0);
    for (int k = 0; k < 4; k++) pair_b(1, 0);
    check("mid_byte_data", ib.out_data, 8'hAA);
    check("mid_byte_last", ib.out_last, 0);
    pair_b(0, 1); pair_b(0, 1);
    check("mid_end_lvl", lvl_b, 2);
    check("mid_end_fd", fd_b, 1);
    ib.out_ready = 1'b1;
    tick();
    check("mid_end_data", ib.out_data, 8'h50);
    check("mid_end_last", ib.out_last, 1);
    tick();
    ib.out_ready = 1'b0;

    // Full FIFO with push and pop on the same edge
    for (int i = 0; i < 9; i++) exp_b[i] = 8'(8'hA0 + i);
    for (int i = 0; i < 8; i++) byte_a(exp_b[i]);
    check("full_lvl", lvl_a, 8);
    pair_a(exp_b[8][7], exp_b[8][6]);
    pair_a(exp_b[8][5], exp_b[8][4]);
    pair_a(exp_b[8][3], exp_b[8][2]);
    ia.out_ready = 1'b1;
    pair_a(exp_b[8][1], exp_b[8][0]);
    ia.out_ready = 1'b0;
    check("pp_lvl", lvl_a, 8);
    check("pp_ovf", ov_a, 0);
    check("pp_head", ia.out_data, exp_b[1]);
    ia.out_ready = 1'b1;
    for (int i = 1; i < 9; i++) begin
      check($sformatf("pp_drain%0d", i), ia.out_data, exp_b[i]);
      tick();
    end
    check("pp_empty", lvl_a, 0);
    ia.out_ready = 1'b0;

    // Continuous 4096-pair frame with random consumer
    do_reset();
    popped = 0;
    for (int k = 0; k < 4096; k++) begin
      ia.in_valid = 1'b1;
      ia.in_bit0 = (k % 2 == 0);
      ia.in_bit1 = (k % 2 != 0);
      ia.out_ready = 1'($urandom_range(0, 1));
      if (ia.out_valid && ia.out_ready) begin
        check("stream_data", ia.out_data, 8'h99);
        check("stream_last", ia.out_last, (popped == 1023) ? 1 : 0);
        popped++;
      end
      tick();
      if (k == 4095) check("stream_fd", fd_a, 1);
    end
    ia.in_valid = 1'b0;
    ia.out_ready = 1'b1;
    for (int c = 0; c < 64 && popped < 1024; c++) begin
      if (ia.out_valid) begin
        check("stream_data", ia.out_data, 8'h99);
        check("stream_last", ia.out_last, (popped == 1023) ? 1 : 0);
        popped++;
      end
      tick();
    end
    check("stream_count", popped, 1024);
    check("stream_ovf", ov_a, 0);
    check("stream_lvl", lvl_a, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
